tt_pin_reg_responder: RTL and testbench
=======================================

# tt_pin_reg_responder

On-chip responder for the host-driven byte-wide pin bus: an external tester drives commands on the dedicated inputs and the bidirectional pins, and this block executes register reads and writes against a 16-entry register file with a four-phase strobe/ack handshake. It sits directly behind the chip's top-level pin ports and is the chip-side end of the same pin interface the cocotb bench drives. It provides a deterministic register-access path for bring-up and silicon test.

## Interface
- No parameters. Register count, ID value and field positions are fixed constants in the package.
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  design selected; low forces IDLE and idle outputs
- ui_in  in  8  [7] strobe (asynchronous to clk), [6] 1=write/0=read, [5:4] unused, [3:0] register address
- uio_in  in  8  write data
- uio_out  out  8  read data
- uio_oe  out  8  0xFF while driving read data, else 0x00
- uo_out  out  8  [7] ack, [6] sticky error, [5:4] FSM state code, [3:0] last executed address

## Operation
- Register map: 0x0–0xD read/write scratch bytes; 0xE read-only write counter (+1 per accepted write, wraps 0xFF→0x00); 0xF read-only ID 0xA5.
- Strobe passes a two-flop synchronizer (s1, s2) plus a delay flop s3; rise = s2 & ~s3.
- FSM states: IDLE (code 00), EXEC (01), ACK (10).
  - IDLE: on rise → EXEC.
  - EXEC: sample ui_in[6:0] and uio_in from the pins. Write to 0x0–0xD: store byte, increment counter. Write to 0xE/0xF: discard, set error. Read: latch register into uio_out; read of 0xF also clears error. Latch address into uo_out[3:0]. Then ack=1 → ACK.
  - ACK: hold ack=1; uio_oe=0xFF if the transaction was a read. When s2=0 → IDLE, ack=0, uio_oe=0x00.
- The host holds address, direction and data stable from strobe rise until it sees ack.
- A new transaction requires the full handshake: strobe must be seen low in ACK before IDLE can accept another rise.
- ena=0 in any state: next edge → IDLE, ack=0, uio_oe=0x00. Register file, counter, error and uio_out are retained.
- Reset values: all scratch registers, counter, error, ack, state and last address are 0. uo_out=0x00, uio_out=0x00, uio_oe=0x00.
- Reset mid-transaction: immediate return to reset values. A write not yet executed in EXEC is lost.

## Timing
- Edge 0 is the first rising edge sampling strobe high. s2=1 at edge 1, EXEC at edge 2. The write commit or read latch, ack=1 and uio_oe drive all happen at edge 3.
- Release: strobe first sampled low at edge m. IDLE, ack=0 and uio_oe=0x00 happen at edge m+2.
- Minimum transaction is about 6 clocks. Strobe pulses shorter than one clock may be missed; any pulse captured by s1 and held into s2 is a full transaction.
- Counter increments on the same edge as the write commit.
- Error sets on the EXEC edge of a read-only write and clears on the EXEC edge of a 0xF read. If both happen on the same edge, set wins; this cannot occur within one transaction.
- All outputs are registered; there is no combinational path from pins to outputs.

## Structure
- Package tt_resp_pkg:
  - state enum {IDLE, EXEC, ACK} with 2-bit codes 00/01/10
  - ADDR_WCNT=4'hE, ADDR_ID=4'hF, ID_VALUE=8'hA5
  - strobe/direction bit indices
- Sub-module tt_sync2: generic two-flop synchronizer with asynchronous active-low reset. Used for strobe only; the s3 delay flop stays in the parent.
- Register file: 14 × 8 flops in the parent.

## Test plan
- Reset, then hold strobe low for 20 clocks → uo_out=0x00, uio_oe=0x00, uio_out=0x00 throughout.
- Write 0x3C to 0x5, then read 0x5 → ack rises exactly at edge 3. During the read ACK, uio_out=0x3C and uio_oe=0xFF. After strobe drops, ack=0 and uio_oe=0x00 at edge m+2. Read 0xE → 0x01.
- Write 0x77 to 0xF → error bit=1 and counter unchanged. Read 0xF → uio_out=0xA5, then error bit=0.
- 256 writes to 0x0 → counter reads 0x00 (wrap). Strobe held high across ACK for 10 clocks → exactly one write counted.
- Drop ena while in ACK of a read → next edge ack=0 and uio_oe=0x00. Re-enable; earlier scratch contents still read back intact.
- Assert rst_n low mid-EXEC → all outputs 0x00 immediately with no clock edge. The scratch register previously 0x3C reads 0x00.

Source files
------------

// File: rtl/tt_pin_reg_responder_pkg.sv
// rtl/tt_pin_reg_responder_pkg.sv - shared types and constants for the pin-bus register responder
package tt_resp_pkg;

    // FSM state; the encoding is exported on uo_out[5:4]
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        ACK  = 2'b10
    } state_t;

    localparam logic [3:0] ADDR_WCNT   = 4'hE;
    localparam logic [3:0] ADDR_ID     = 4'hF;
    localparam logic [7:0] ID_VALUE    = 8'hA5;

    // ui_in bit positions
    localparam int STB_BIT     = 7;
    localparam int DIR_BIT     = 6;

    localparam int NUM_SCRATCH = 14;

    // Scratch bytes occupy every address below the write counter
    function automatic logic is_scratch(input logic [3:0] addr);
        return addr < ADDR_WCNT;
    endfunction

endpackage

// File: rtl/tt_pin_reg_responder_if.sv
// rtl/tt_pin_reg_responder_if.sv - byte-wide pin bus between tester and on-chip responder
interface tt_pin_reg_responder_if;

    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] uo_out;

    // Tester side: drives commands and write data, observes ack/status/read data
    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uio_out,
        input  uio_oe,
        input  uo_out
    );

    // Responder side
    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uio_out,
        output uio_oe,
        output uo_out
    );

endinterface

// File: rtl/tt_pin_reg_responder_sync2.sv
// rtl/tt_pin_reg_responder_sync2.sv - generic two-flop synchronizer
module tt_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First flop may go metastable; second flop gives it a cycle to settle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tt_pin_reg_responder.sv
// rtl/tt_pin_reg_responder.sv - register read/write responder with four-phase strobe/ack handshake
module tt_pin_reg_responder
    import tt_resp_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    tt_pin_reg_responder_if.slave  pins
);

    logic       s2;
    logic       s3;
    logic       rise;

    state_t     state_q;
    state_t     state_d;

    logic       exec;
    logic       is_wr;
    logic [3:0] addr;
    logic       do_store;
    logic       do_reject;
    logic       do_read;
    logic       do_id_read;
    logic       ack_d;
    logic       oe_d;
    logic       txn_rd_d;
    logic [7:0] rd_val;

    logic [7:0] regs [NUM_SCRATCH];
    logic [7:0] wcnt_q;
    logic       err_q;
    logic [7:0] rdata_q;
    logic [3:0] last_addr_q;
    logic       ack_q;
    logic       oe_q;
    logic       txn_rd_q;

    logic       unused_pins;
    assign unused_pins = ^pins.ui_in[5:4];

    tt_sync2 #(.WIDTH(1)) u_stb_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pins.ui_in[STB_BIT]),
        .q     (s2)
    );

    // Delay flop so a strobe that stays high produces a single rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3 <= 1'b0;
        end else begin
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: disable overrides everything; ACK waits for strobe release
    always_comb begin
        state_d = state_q;
        if (!pins.ena) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (rise) state_d = EXEC;
                EXEC:    state_d = ACK;
                ACK:     if (!s2) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output/action decode: what EXEC does this cycle and what ack/oe become
    always_comb begin
        exec       = pins.ena && (state_q == EXEC);
        is_wr      = pins.ui_in[DIR_BIT];
        addr       = pins.ui_in[3:0];
        do_store   = exec && is_wr && is_scratch(addr);
        do_reject  = exec && is_wr && !is_scratch(addr);
        do_read    = exec && !is_wr;
        do_id_read = do_read && (addr == ADDR_ID);
        txn_rd_d   = exec ? !is_wr : txn_rd_q;
        ack_d      = (state_d == ACK);
        oe_d       = (state_d == ACK) && txn_rd_d;
    end

    // Read mux over scratch bytes, counter and ID
    always_comb begin
        rd_val = 8'h00;
        if (addr == ADDR_WCNT) begin
            rd_val = wcnt_q;
        end else if (addr == ADDR_ID) begin
            rd_val = ID_VALUE;
        end else begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (addr == i[3:0]) rd_val = regs[i];
            end
        end
    end

    // Scratch register file, written only from EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SCRATCH; i++) regs[i] <= 8'h00;
        end else begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (do_store && (addr == i[3:0])) regs[i] <= pins.uio_in;
            end
        end
    end

    // Transaction side effects: counter, sticky error, read data, last address, handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q      <= 8'h00;
            err_q       <= 1'b0;
            rdata_q     <= 8'h00;
            last_addr_q <= 4'h0;
            ack_q       <= 1'b0;
            oe_q        <= 1'b0;
            txn_rd_q    <= 1'b0;
        end else begin
            if (do_store) wcnt_q <= wcnt_q + 8'h01;
            if (do_reject) begin
                err_q <= 1'b1;
            end else if (do_id_read) begin
                err_q <= 1'b0;
            end
            if (do_read) rdata_q <= rd_val;
            if (exec) last_addr_q <= addr;
            ack_q    <= ack_d;
            oe_q     <= oe_d;
            txn_rd_q <= txn_rd_d;
        end
    end

    assign pins.uo_out  = {ack_q, err_q, state_q, last_addr_q};
    assign pins.uio_out = rdata_q;
    assign pins.uio_oe  = {8{oe_q}};

endmodule

// File: tb/tb_tt_pin_reg_responder.sv
// tb/tb_tt_pin_reg_responder.sv - scoreboard bench for the pin-bus register responder
module tb_tt_pin_reg_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    tt_pin_reg_responder_if pins ();

    tt_pin_reg_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pins  (pins)
    );

    typedef struct {
        logic       rd;
        logic [3:0] addr;
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t       sbq[$];
    int         checks = 0;
    int         errors = 0;
    logic       m_err;
    logic [7:0] m_rd;
    logic       prev_ack = 1'b0;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%02h required=%02h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: on every ack rise, pop the expected response and compare the pins
    always @(negedge clk) begin
        exp_t e;
        if (pins.uo_out[7] && !prev_ack) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_unexpected_ack actual=%02h required=none", pins.uo_out);
            end else begin
                e = sbq.pop_front();
                check8("mon_uo_out", pins.uo_out, {1'b1, e.err, 2'b10, e.addr});
                check8("mon_uio_out", pins.uio_out, e.data);
                check8("mon_uio_oe", pins.uio_oe, e.rd ? 8'hFF : 8'h00);
            end
        end
        prev_ack = pins.uo_out[7];
    end

    // Issue a command, push its expected response, and time the ack rise from edge 0
    task automatic start_txn(input bit wr, input logic [3:0] a, input logic [7:0] d,
                             input logic [7:0] exp_rd);
        exp_t e;
        int   k;
        if (wr) begin
            if (a == 4'hE || a == 4'hF) m_err = 1'b1;
        end else begin
            if (a == 4'hF) m_err = 1'b0;
            m_rd = exp_rd;
        end
        e.rd   = !wr;
        e.addr = a;
        e.data = m_rd;
        e.err  = m_err;
        sbq.push_back(e);
        @(negedge clk);
        pins.ui_in  = {1'b1, wr, 2'b00, a};
        pins.uio_in = d;
        for (k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (pins.uo_out[7]) break;
        end
        check_int("ack_latency", k, 3);
    endtask

    // Drop strobe and time the ack fall from edge m
    task automatic end_txn();
        int j;
        @(negedge clk);
        pins.ui_in[7] = 1'b0;
        for (j = 0; j < 10; j++) begin
            @(posedge clk);
            #1;
            if (!pins.uo_out[7]) break;
        end
        check_int("release_latency", j, 2);
        check8("release_oe", pins.uio_oe, 8'h00);
    endtask

    task automatic txn(input bit wr, input logic [3:0] a, input logic [7:0] d,
                       input logic [7:0] exp_rd, input int hold = 0);
        start_txn(wr, a, d, exp_rd);
        repeat (hold) @(posedge clk);
        end_txn();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pins.ena    = 1'b1;
        pins.ui_in  = 8'h00;
        pins.uio_in = 8'h00;
        m_err       = 1'b0;
        m_rd        = 8'h00;

        #2;
        check8("reset_uo_out", pins.uo_out, 8'h00);
        check8("reset_uio_out", pins.uio_out, 8'h00);
        check8("reset_uio_oe", pins.uio_oe, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check8("idle_uo_out", pins.uo_out, 8'h00);
            check8("idle_uio_oe", pins.uio_oe, 8'h00);
            check8("idle_uio_out", pins.uio_out, 8'h00);
        end

        // Counter wrap: 256 scratch writes bring it back to zero
        for (int i = 0; i < 256; i++) txn(1'b1, 4'h0, i[7:0], 8'h00);
        txn(1'b0, 4'h0, 8'h00, 8'hFF);
        txn(1'b0, 4'hE, 8'h00, 8'h00);

        // Strobe held across ACK for 10 clocks counts exactly one write
        txn(1'b1, 4'h5, 8'h3C, 8'h00, 10);
        txn(1'b0, 4'h5, 8'h00, 8'h3C);
        txn(1'b0, 4'hE, 8'h00, 8'h01);

        // Read-only write sets error without counting; ID read clears it
        txn(1'b1, 4'hF, 8'h77, 8'h00);
        check8("err_after_ro_write", {7'b0, pins.uo_out[6]}, 8'h01);
        txn(1'b0, 4'hE, 8'h00, 8'h01);
        txn(1'b0, 4'hF, 8'h00, 8'hA5);
        check8("err_after_id_read", {7'b0, pins.uo_out[6]}, 8'h00);

        // Disable during a read ACK
        start_txn(1'b0, 4'h5, 8'h00, 8'h3C);
        @(negedge clk);
        pins.ena = 1'b0;
        @(posedge clk);
        #1;
        check8("ena_off_ack", {7'b0, pins.uo_out[7]}, 8'h00);
        check8("ena_off_oe", pins.uio_oe, 8'h00);
        check8("ena_off_state", {6'b0, pins.uo_out[5:4]}, 8'h00);
        check8("ena_off_rdata", pins.uio_out, 8'h3C);
        @(negedge clk);
        pins.ui_in[7] = 1'b0;
        repeat (3) @(negedge clk);
        pins.ena = 1'b1;
        repeat (2) @(negedge clk);
        txn(1'b0, 4'h5, 8'h00, 8'h3C);

        // Reset asserted while in EXEC of a write
        @(negedge clk);
        pins.ui_in  = {1'b1, 1'b1, 2'b00, 4'h5};
        pins.uio_in = 8'h11;
        repeat (3) @(posedge clk);
        #1;
        check8("mid_exec_state", {6'b0, pins.uo_out[5:4]}, 8'h01);
        rst_n = 1'b0;
        #1;
        check8("async_rst_uo_out", pins.uo_out, 8'h00);
        check8("async_rst_uio_out", pins.uio_out, 8'h00);
        check8("async_rst_uio_oe", pins.uio_oe, 8'h00);
        @(negedge clk);
        pins.ui_in = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        m_err = 1'b0;
        m_rd  = 8'h00;
        repeat (3) @(negedge clk);
        txn(1'b0, 4'h5, 8'h00, 8'h00);
        txn(1'b0, 4'hE, 8'h00, 8'h00);

        repeat (4) @(negedge clk);
        check_int("scoreboard_drained", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
